// File: rtl/clock_display_pkg.sv
// Shared constants for the HH:MM:SS multiplexed 7-segment display: segment codes, digit
// indices and edit-field encoding.
package clock_display_pkg;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [5:0] AN_OFF   = 6'h3F;

    localparam logic [2:0] IDX_SEC_ONES  = 3'd0;
    localparam logic [2:0] IDX_SEC_TENS  = 3'd1;
    localparam logic [2:0] IDX_MIN_ONES  = 3'd2;
    localparam logic [2:0] IDX_MIN_TENS  = 3'd3;
    localparam logic [2:0] IDX_HOUR_ONES = 3'd4;
    localparam logic [2:0] IDX_HOUR_TENS = 3'd5;

    typedef enum logic [1:0] {
        FieldNone = 2'd0,
        FieldSec  = 2'd1,
        FieldMin  = 2'd2,
        FieldHour = 2'd3
    } field_e;

    function automatic logic [6:0] seg_code(input logic [3:0] digit, input logic dash);
        if (dash || (digit > 4'd9)) begin
            return SEG_DASH;
        end
        return SEG_DIGIT[digit];
    endfunction

    function automatic field_e field_of(input logic [2:0] idx);
        case (idx)
            IDX_SEC_ONES, IDX_SEC_TENS:   return FieldSec;
            IDX_MIN_ONES, IDX_MIN_TENS:   return FieldMin;
            IDX_HOUR_ONES, IDX_HOUR_TENS: return FieldHour;
            default:                      return FieldNone;
        endcase
    endfunction

endpackage

// File: rtl/clock_display_scan_bin2bcd.sv
// Two-digit binary-to-BCD converter for one time field, flagging values above LIMIT.
module bin2bcd_2digit #(
    parameter int unsigned LIMIT = 59
) (
    input  logic [7:0] value,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       out_of_range
);

    always_comb begin
        tens         = 4'(value / 8'd10);
        ones         = 4'(value % 8'd10);
        out_of_range = (value > 8'(LIMIT));
    end

endmodule

// File: rtl/clock_display_scan.sv
// Scans snapshotted sec/min/hour onto a 6-digit multiplexed 7-seg display with a blank window
// after every digit switch. Define CLOCK_DISPLAY_BLINK_EN to blink the field chosen by edit_sel.
module clock_display_scan
    import clock_display_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SCAN_HZ      = 6_000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned BLINK_HZ     = 2
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [7:0] sec,
    input  logic [7:0] min,
    input  logic [7:0] hour,
    input  logic [1:0] edit_sel,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    snap_sec_q, snap_min_q, snap_hour_q;
    logic          scan_tick, frame_wrap, blank_field;
    logic [5:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    logic [3:0] sec_tens, sec_ones, min_tens, min_ones, hour_tens, hour_ones;
    logic       sec_oor, min_oor, hour_oor;

    bin2bcd_2digit #(.LIMIT(59)) u_sec (
        .value(snap_sec_q), .tens(sec_tens), .ones(sec_ones), .out_of_range(sec_oor)
    );
    bin2bcd_2digit #(.LIMIT(59)) u_min (
        .value(snap_min_q), .tens(min_tens), .ones(min_ones), .out_of_range(min_oor)
    );
    bin2bcd_2digit #(.LIMIT(23)) u_hour (
        .value(snap_hour_q), .tens(hour_tens), .ones(hour_ones), .out_of_range(hour_oor)
    );

    always_comb begin
        scan_tick  = (presc_q == PW'(DIV - 1));
        frame_wrap = scan_tick && (idx_q == IDX_HOUR_TENS);
        presc_d    = scan_tick ? '0 : presc_q + 1'b1;
        idx_d      = idx_q;
        if (scan_tick) begin
            idx_d = (idx_q == IDX_HOUR_TENS) ? IDX_SEC_ONES : idx_q + 3'd1;
        end
    end

`ifdef CLOCK_DISPLAY_BLINK_EN
    localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned BW   = (HALF > 2) ? $clog2(HALF) : 1;

    logic [BW-1:0] blink_cnt_q;
    logic          phase_q;
    field_e        sel_q;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            sel_q       <= FieldNone;
        end else begin
            if (blink_cnt_q == BW'(HALF - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
            // Edited field only moves on a digit switch so a digit is never cut mid-window.
            if (scan_tick) begin
                sel_q <= field_e'(edit_sel);
            end
        end
    end

    assign blank_field = phase_q && (sel_q != FieldNone) && (field_of(idx_q) == sel_q);
`else
    logic unused_edit_sel;
    assign unused_edit_sel = ^edit_sel;
    assign blank_field     = 1'b0;
`endif

    always_comb begin
        seg_d = SEG_OFF;
        case (idx_q)
            IDX_SEC_ONES:  seg_d = seg_code(sec_ones, sec_oor);
            IDX_SEC_TENS:  seg_d = seg_code(sec_tens, sec_oor);
            IDX_MIN_ONES:  seg_d = seg_code(min_ones, min_oor);
            IDX_MIN_TENS:  seg_d = seg_code(min_tens, min_oor);
            IDX_HOUR_ONES: seg_d = seg_code(hour_ones, hour_oor);
            IDX_HOUR_TENS: seg_d = seg_code(hour_tens, hour_oor);
            default:       seg_d = SEG_OFF;
        endcase
        dp_d = !((idx_q == IDX_MIN_ONES) || (idx_q == IDX_HOUR_ONES));
        // Anodes stay off while the prescaler is inside the blank window after a switch.
        if ((presc_q < PW'(BLANK_CYCLES)) || blank_field) begin
            an_d = AN_OFF;
        end else begin
            an_d = ~(6'b1 << idx_q);
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            idx_q       <= IDX_SEC_ONES;
            snap_sec_q  <= '0;
            snap_min_q  <= '0;
            snap_hour_q <= '0;
            an          <= AN_OFF;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            if (frame_wrap) begin
                snap_sec_q  <= sec;
                snap_min_q  <= min;
                snap_hour_q <= hour;
            end
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench for clock_display_scan: cycle reference model from an input history,
// table-driven frame captures and hand sequences for frame-wrap and reset corner cases.
module tb_clock_display_scan;

    localparam int DIV   = 6;
    localparam int HALF  = 6;
    localparam int BLANK = 2;
    localparam int FRAME = 6 * DIV;
    localparam int HMAX  = 16384;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sec = 8'd0, min = 8'd0, hour = 8'd0;
    logic [1:0] edit_sel = 2'd0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    always #5 clk = ~clk;

    clock_display_scan #(
        .CLK_HZ(600), .SCAN_HZ(100), .BLANK_CYCLES(2), .BLINK_HZ(50)
    ) dut (
        .clk_100MHz(clk), .reset(reset), .sec(sec), .min(min), .hour(hour),
        .edit_sel(edit_sel), .an(an), .seg(seg), .dp(dp)
    );

    typedef struct packed {
        logic [7:0]      s;
        logic [7:0]      m;
        logic [7:0]      h;
        logic [5:0][6:0] exp;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         t = 0;
    logic [7:0] h_sec [HMAX];
    logic [7:0] h_min [HMAX];
    logic [7:0] h_hour[HMAX];
    logic [1:0] h_sel [HMAX];
    logic [6:0] seg_tab[10];
    logic [6:0] cap_seg[6];
    bit         cap_seen[6];
    vec_t       vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%h expected=%h", name, t, got, exp);
        end
    endtask

    function automatic logic [6:0] field_seg(input int v, input int limit, input bit tens);
        if (v > limit) return 7'h3F;
        return seg_tab[tens ? v / 10 : v % 10];
    endfunction

    // Outputs after edge t reflect the scan position of the state before that edge.
    task automatic model(output logic [5:0] e_an, output logic [6:0] e_seg, output logic e_dp);
        int q, cnt, idx, fb, s, m, h;
        if (t == 0) begin
            e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
            return;
        end
        q   = t - 1;
        cnt = q % DIV;
        idx = (q / DIV) % 6;
        fb  = (q / FRAME) * FRAME;
        s = 0; m = 0; h = 0;
        if (fb > 0) begin
            s = int'(h_sec[fb]); m = int'(h_min[fb]); h = int'(h_hour[fb]);
        end
        case (idx)
            0: e_seg = field_seg(s, 59, 1'b0);
            1: e_seg = field_seg(s, 59, 1'b1);
            2: e_seg = field_seg(m, 59, 1'b0);
            3: e_seg = field_seg(m, 59, 1'b1);
            4: e_seg = field_seg(h, 23, 1'b0);
            default: e_seg = field_seg(h, 23, 1'b1);
        endcase
        e_dp = !(idx == 2 || idx == 4);
        e_an = (cnt < BLANK) ? 6'h3F : ~(6'b1 << idx);
`ifdef CLOCK_DISPLAY_BLINK_EN
        begin
            int sb, sel;
            sb  = (q / DIV) * DIV;
            sel = (sb == 0) ? 0 : int'(h_sel[sb]);
            if (((q / HALF) % 2 == 1) && sel != 0 && (idx / 2 + 1) == sel) e_an = 6'h3F;
        end
`endif
    endtask

    task automatic step();
        logic [5:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        @(posedge clk);
        t++;
        if (t >= HMAX) begin
            $display("FAIL history_overflow t=%0d limit=%0d", t, HMAX);
            $fatal(1);
        end
        h_sec[t] = sec; h_min[t] = min; h_hour[t] = hour; h_sel[t] = edit_sel;
        #1;
        model(e_an, e_seg, e_dp);
        check("an", an, e_an);
        check("seg", seg, e_seg);
        check("dp", dp, e_dp);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_pos(input int idx, input int cnt);
        for (int k = 0; k < 4 * FRAME; k++) begin
            if (t > 0 && ((t - 1) / DIV) % 6 == idx && (t - 1) % DIV == cnt) return;
            step();
        end
        n_cmp++; n_bad++;
        $display("FAIL wait_pos timeout idx=%0d cnt=%0d", idx, cnt);
    endtask

    task automatic capture_frame();
        for (int i = 0; i < 6; i++) cap_seen[i] = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            step();
            for (int i = 0; i < 6; i++) begin
                if (an == ~(6'b1 << i)) begin
                    cap_seg[i] = seg; cap_seen[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_frame(input string name, input logic [5:0][6:0] exp);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_seen%0d", name, i), 32'(cap_seen[i]), 32'd1);
            check($sformatf("%s_idx%0d", name, i), cap_seg[i], exp[i]);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        t = 0;
        #1;
        check("post_release_an", an, 6'h3F);
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        vecs[0] = '{s: 8'd56, m: 8'd34, h: 8'd12,
                    exp: {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
        vecs[1] = '{s: 8'd59, m: 8'd59, h: 8'd23,
                    exp: {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}};
        vecs[2] = '{s: 8'd0, m: 8'd0, h: 8'd0,
                    exp: {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[3] = '{s: 8'd5, m: 8'd60, h: 8'd24,
                    exp: {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h40, 7'h12}};
        vecs[4] = '{s: 8'd0, m: 8'd7, h: 8'd9,
                    exp: {7'h40, 7'h10, 7'h40, 7'h78, 7'h40, 7'h40}};
        vecs[5] = '{s: 8'd60, m: 8'd0, h: 8'd23,
                    exp: {7'h24, 7'h30, 7'h40, 7'h40, 7'h3F, 7'h3F}};

        // Reset state
        #12;
        check("reset_an", an, 6'h3F);
        check("reset_seg", seg, 7'h7F);
        check("reset_dp", dp, 1'b1);
        release_reset();
        sec = 8'd56; min = 8'd34; hour = 8'd12;

        // First frame shows the zero snapshot; first digit enabled after edge 3
        run(3);
        check("first_digit_an", an, 6'h3E);
        check("first_digit_seg", seg, 7'h40);
        run(FRAME - 3);
        capture_frame();
        check_frame("frame2", vecs[0].exp);

        for (int v = 0; v < 6; v++) begin
            sec = vecs[v].s; min = vecs[v].m; hour = vecs[v].h;
            run(2 * FRAME);
            capture_frame();
            check_frame($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Seconds change mid-frame only shows after the next wrap
        sec = 8'd56; min = 8'd34; hour = 8'd12;
        run(2 * FRAME);
        wait_pos(2, 3);
        sec = 8'd57;
        wait_pos(0, 3);
        check("sec57_next_frame_an", an, 6'h3E);
        check("sec57_next_frame_seg", seg, 7'h78);

        // Inputs change right after a wrap edge: whole frame old, then whole frame new
        sec = 8'd59; min = 8'd59; hour = 8'd23;
        run(2 * FRAME);
        for (int k = 0; k < FRAME && (t % FRAME) != 0; k++) step();
        sec = 8'd0; min = 8'd0; hour = 8'd0;
        capture_frame();
        check_frame("wrap_old", vecs[1].exp);
        capture_frame();
        check_frame("wrap_new", vecs[2].exp);

        // Random inputs, occasionally out of range, against the model
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                sec      = 8'($urandom_range(0, 63));
                min      = 8'($urandom_range(0, 63));
                hour     = 8'($urandom_range(0, 31));
                edit_sel = 2'($urandom_range(0, 3));
            end
            step();
        end

        // Minutes field selected for editing
        sec = 8'd56; min = 8'd34; hour = 8'd12; edit_sel = 2'd2;
        run(4 * FRAME);
        edit_sel = 2'd0;
        run(FRAME);

        // Async reset mid-digit at idx 3
        wait_pos(3, 3);
        reset = 1'b1;
        #1;
        check("midreset_an", an, 6'h3F);
        check("midreset_seg", seg, 7'h7F);
        check("midreset_dp", dp, 1'b1);
        @(posedge clk);
        #1;
        check("midreset_hold_an", an, 6'h3F);
        release_reset();
        wait_pos(0, 2);
        check("restart_idx0_an", an, 6'h3E);
        check("restart_idx0_seg", seg, 7'h40);
        run(2 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
